// File: rtl/mult_div_engine_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared definitions for the mult/div engine and its requester.
//   MD_OP_MULT / MD_OP_DIV : encoding of the op bit on the handshake
//   md_state_t             : engine sequencing states
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic MD_OP_MULT = 1'b0;
   localparam logic MD_OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2,
      MD_DZ   = 2'd3
   } md_state_t;

endpackage

// File: rtl/mult_div_engine_if.sv
// ---------------------------------------------------------------------------
// mult_div_engine_if: mult/div request/response handshake.
//   master (control unit): drives start, op, a_in, b_in; receives results
//   slave  (engine)      : receives the request; drives hi_out, lo_out,
//                          done, div_by_zero, busy
// ---------------------------------------------------------------------------
interface mult_div_engine_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             done;
   logic             div_by_zero;
   logic             busy;

   modport master (
      output start, op, a_in, b_in,
      input  hi_out, lo_out, done, div_by_zero, busy
   );

   modport slave (
      input  start, op, a_in, b_in,
      output hi_out, lo_out, done, div_by_zero, busy
   );
endinterface

// File: rtl/mult_div_engine_negate.sv
// ---------------------------------------------------------------------------
// md_negate: combinational conditional two's-complement negation.
//   neg_i : 1 = output -val_i (modulo 2^N), 0 = output val_i
//   val_i : N-bit input value
//   res_o : N-bit result
// ---------------------------------------------------------------------------
module md_negate #(
   parameter int N = 32
) (
   input  logic         neg_i,
   input  logic [N-1:0] val_i,
   output logic [N-1:0] res_o
);

   // Invert-and-increment; the most negative value maps onto itself.
   always_comb begin
      if (neg_i) begin
         res_o = ~val_i + {{(N-1){1'b0}}, 1'b1};
      end else begin
         res_o = val_i;
      end
   end

endmodule

// File: rtl/mult_div_engine.sv
// ---------------------------------------------------------------------------
// mult_div_engine: iterative signed WIDTHxWIDTH multiply / WIDTH/WIDTH divide.
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   md    : slave side of the mult/div handshake
//             start/op/a_in/b_in sampled in IDLE only
//             hi_out/lo_out : MULT product[2W-1:W]/[W-1:0], DIV remainder/quotient
//             done          : one-cycle pulse, result valid from that cycle
//             div_by_zero   : one-cycle pulse, DIV by zero, results untouched
//             busy          : high in every state but IDLE
// Operation works on magnitudes for WIDTH RUN cycles, then one FIX cycle
// restores the signs, giving a 33-cycle start-to-done latency at WIDTH=32.
// ---------------------------------------------------------------------------
module mult_div_engine
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic              clock,
   input logic              reset,
   mult_div_engine_if.slave md
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   md_state_t          state_q;
   logic [CW-1:0]      cnt_q;
   logic               op_q;
   logic               neg_res_q;   // sign(a) ^ sign(b)
   logic               neg_rem_q;   // sign of the dividend
   logic [WIDTH-1:0]   opa_q;       // |a| for MULT (addend), |b| for DIV (divisor)
   logic [2*WIDTH-1:0] acc_q;       // MULT {product hi, multiplier/lo}; DIV {rem, quotient/dividend}
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dz_q;
   logic               busy_q;

   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_part;
   logic [WIDTH:0]     div_diff;

   // Operand magnitudes; 0x80000000 stays 0x80000000 and is read as unsigned.
   md_negate #(.N(WIDTH)) u_abs_a (.neg_i(md.a_in[WIDTH-1]), .val_i(md.a_in), .res_o(a_abs));
   md_negate #(.N(WIDTH)) u_abs_b (.neg_i(md.b_in[WIDTH-1]), .val_i(md.b_in), .res_o(b_abs));

   // Sign fix-up of the finished magnitude results.
   md_negate #(.N(2*WIDTH)) u_fix_prod (.neg_i(neg_res_q), .val_i(acc_q),                 .res_o(prod_fix));
   md_negate #(.N(WIDTH))   u_fix_quo  (.neg_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]),       .res_o(quo_fix));
   md_negate #(.N(WIDTH))   u_fix_rem  (.neg_i(neg_rem_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .res_o(rem_fix));

   // One iteration step: shift-add for MULT, restoring subtract for DIV.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
      div_part = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_part - {1'b0, opa_q};
      acc_d    = acc_q;
      if (op_q == MD_OP_DIV) begin
         // Partial remainder stays below 2*divisor, so bit WIDTH is a valid borrow.
         if (!div_diff[WIDTH]) begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Carry out of the add becomes the new top bit after the right shift.
         if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
         end
      end
   end

   // Sequencer, iteration counter, datapath and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         cnt_q     <= {CW{1'b0}};
         op_q      <= MD_OP_MULT;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opa_q     <= {WIDTH{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            MD_IDLE: begin
               if (md.start) begin
                  op_q      <= md.op;
                  neg_res_q <= md.a_in[WIDTH-1] ^ md.b_in[WIDTH-1];
                  neg_rem_q <= md.a_in[WIDTH-1];
                  cnt_q     <= {CW{1'b0}};
                  busy_q    <= 1'b1;
                  if (md.op == MD_OP_DIV) begin
                     opa_q <= b_abs;
                     acc_q <= {{WIDTH{1'b0}}, a_abs};
                  end else begin
                     opa_q <= a_abs;
                     acc_q <= {{WIDTH{1'b0}}, b_abs};
                  end
                  if ((md.op == MD_OP_DIV) && (md.b_in == {WIDTH{1'b0}})) begin
                     state_q <= MD_DZ;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= MD_RUN;
                  end
               end else begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            MD_RUN: begin
               acc_q  <= acc_d;
               busy_q <= 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= MD_FIX;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            MD_FIX: begin
               if (op_q == MD_OP_MULT) begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= MD_IDLE;
            end
            MD_DZ: begin
               busy_q  <= 1'b0;
               state_q <= MD_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= MD_IDLE;
            end
         endcase
      end
   end

   assign md.hi_out      = hi_q;
   assign md.lo_out      = lo_q;
   assign md.done        = done_q;
   assign md.div_by_zero = dz_q;
   assign md.busy        = busy_q;

endmodule

// File: tb/tb_mult_div_engine.sv
// ---------------------------------------------------------------------------
// tb_mult_div_engine: directed bench for mult_div_engine.
// A cycle-level reference (signed 64-bit arithmetic plus start/done timing)
// is compared against every DUT output on every falling edge; hand-computed
// results and latencies are checked on top of that.
// ---------------------------------------------------------------------------
module tb_mult_div_engine;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   mult_div_engine_if #(.WIDTH(W)) md_bus ();

   mult_div_engine #(.WIDTH(W)) dut (
      .clock (clk),
      .reset (rst),
      .md    (md_bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int start_edge = 0;

   // ---------------- reference model ----------------
   longint m_edge     = 0;
   longint done_edge  = -1;
   longint dz_edge    = -1;
   longint busy_first = 0;
   longint busy_last  = -1;
   longint free_edge  = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
   bit m_valid = 1'b0;

   function automatic void model_result(input logic op, input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      m_edge++;
      if (rst) begin
         m_hi = '0; m_lo = '0;
         done_edge = -1; dz_edge = -1;
         busy_first = 0; busy_last = -1; free_edge = 0;
      end else begin
         if (m_edge == done_edge) begin
            m_hi = pend_hi;
            m_lo = pend_lo;
         end
         if (md_bus.start === 1'b1 && m_edge >= free_edge) begin
            busy_first = m_edge;
            if (md_bus.op === 1'b1 && md_bus.b_in == '0) begin
               dz_edge   = m_edge;
               busy_last = m_edge;
               free_edge = m_edge + 2;
            end else begin
               model_result(md_bus.op, md_bus.a_in, md_bus.b_in, pend_hi, pend_lo);
               done_edge = m_edge + 33;
               busy_last = m_edge + 32;
               free_edge = m_edge + 34;
            end
         end
      end
      m_valid = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   logic [66:0] act_v, exp_v;
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         act_v = {md_bus.busy, md_bus.done, md_bus.div_by_zero, md_bus.hi_out, md_bus.lo_out};
         exp_v = {(m_edge >= busy_first && m_edge <= busy_last), (m_edge == done_edge),
                  (m_edge == dz_edge), m_hi, m_lo};
         n_vec++;
         if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_model edge %0d: got busy=%b done=%b dz=%b hi=%h lo=%h, want busy=%b done=%b dz=%b hi=%h lo=%h",
                     m_edge, act_v[66], act_v[65], act_v[64], act_v[63:32], act_v[31:0],
                     exp_v[66], exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Called at a falling edge; start is sampled on the next rising edge.
   task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      md_bus.start = 1'b1;
      md_bus.op    = op;
      md_bus.a_in  = a;
      md_bus.b_in  = b;
      start_edge   = cyc + 1;
      @(negedge clk);
      md_bus.start = 1'b0;
      md_bus.op    = ~op;
      md_bus.a_in  = 32'hDEAD_BEEF;
      md_bus.b_in  = 32'h0000_0000;
   endtask

   task automatic wait_done(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
      int k;
      k = 0;
      while (md_bus.done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (md_bus.done !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_timeout: done=%b after 40 cycles, want 1", name, md_bus.done);
      end else begin
         check({name, "_latency"}, 64'(cyc - start_edge), 64'd33);
         check({name, "_result"}, {md_bus.hi_out, md_bus.lo_out}, {eh, el});
      end
   endtask

   // ---------------- directed vectors ----------------
   logic         t_op [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [W-1:0] t_a  [9] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000,
                              32'h0000_0064, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0003,
                              32'hFFFF_FF9C};
   logic [W-1:0] t_b  [9] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0007,
                              32'h0000_0007};
   logic [W-1:0] t_hi [9] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                              32'h0000_0002, 32'h0000_0000, 32'h3FFF_FFFF, 32'h0000_0003,
                              32'hFFFF_FFFE};
   logic [W-1:0] t_lo [9] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFD, 32'h8000_0000,
                              32'hFFFF_FFF2, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000,
                              32'hFFFF_FFF2};

   initial begin
      rst          = 1'b1;
      md_bus.start = 1'b0;
      md_bus.op    = 1'b0;
      md_bus.a_in  = '0;
      md_bus.b_in  = '0;
      repeat (3) @(negedge clk);
      check("reset_hilo", {md_bus.hi_out, md_bus.lo_out}, 64'h0);
      check("reset_flags", {61'd0, md_bus.busy, md_bus.done, md_bus.div_by_zero}, 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         start_op(t_op[i], t_a[i], t_b[i]);
         wait_done($sformatf("vec%0d", i), t_hi[i], t_lo[i]);
      end

      // Divide by zero: pulse, no result, outputs keep the previous result.
      @(negedge clk);
      start_op(1'b1, 32'h0000_0005, 32'h0000_0000);
      check("dz_pulse", {61'd0, md_bus.div_by_zero, md_bus.done, md_bus.busy}, 64'h5);
      check("dz_hold", {md_bus.hi_out, md_bus.lo_out}, 64'hFFFF_FFFE_FFFF_FFF2);
      @(negedge clk);
      check("dz_end", {61'd0, md_bus.div_by_zero, md_bus.done, md_bus.busy}, 64'h0);
      repeat (3) @(negedge clk);

      // Start while busy is ignored; start in the done cycle is accepted.
      start_op(1'b0, 32'd100, 32'd200);
      repeat (9) @(negedge clk);
      md_bus.start = 1'b1;
      md_bus.op    = 1'b1;
      md_bus.a_in  = 32'h0000_0001;
      md_bus.b_in  = 32'h0000_0000;
      @(negedge clk);
      md_bus.start = 1'b0;
      wait_done("busy_start", 32'h0000_0000, 32'h0000_4E20);
      start_op(1'b0, 32'hFFFF_FFFB, 32'h0000_0006);
      wait_done("done_cycle_start", 32'hFFFF_FFFF, 32'hFFFF_FFE2);

      // Reset in the middle of a DIV aborts it.
      @(negedge clk);
      start_op(1'b1, 32'd1000, 32'd7);
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_flags", {61'd0, md_bus.busy, md_bus.done, md_bus.div_by_zero}, 64'h0);
      check("abort_hilo", {md_bus.hi_out, md_bus.lo_out}, 64'h0);
      repeat (35) @(negedge clk);
      start_op(1'b0, 32'd3, 32'd4);
      wait_done("post_reset", 32'h0000_0000, 32'h0000_000C);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
